// File: rtl/mac_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_arb_pkg
// Purpose  : Shared types and constants for the MAC transmit arbiter.
//            Holds the arbiter FSM state type, the source-count ceiling,
//            AXI-Stream lane widths and a one-hot to index helper.
// Revision : 1.0 - initial release
// ============================================================================
package mac_tx_arb_pkg;

    localparam int MAX_SOURCES = 8;
    localparam int c_idx_w     = $clog2(MAX_SOURCES);
    localparam int c_data_w    = 64;
    localparam int c_keep_w    = 8;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } tx_arb_state_t;

    // Index of the set bit of a one-hot vector; 0 when no bit is set.
    function automatic logic [c_idx_w-1:0] onehot_to_idx(input logic [MAX_SOURCES-1:0] oh);
        logic [c_idx_w-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SOURCES; i++) begin
            if (oh[i]) begin
                idx = c_idx_w'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_arbiter_if
// Purpose  : AXI-Stream bundle around the transmit arbiter: NUM_SOURCES
//            packed user streams on the s_axis side (source n on lanes
//            [n*64 +: 64] / [n*8 +: 8] / [n]) and the single m00_axis
//            stream toward the MAC.
// Modports : slave  - the arbiter (consumes s_axis, drives m00_axis)
//            master - the environment (drives s_axis, consumes m00_axis)
// Revision : 1.0 - initial release
// ============================================================================
interface mac_tx_arbiter_if #(
    parameter int NUM_SOURCES = 2
);
    import mac_tx_arb_pkg::*;

    logic [NUM_SOURCES*c_data_w-1:0] s_axis_tdata;
    logic [NUM_SOURCES*c_keep_w-1:0] s_axis_tkeep;
    logic [NUM_SOURCES-1:0]          s_axis_tvalid;
    logic [NUM_SOURCES-1:0]          s_axis_tlast;
    logic [NUM_SOURCES-1:0]          s_axis_tready;

    logic [c_data_w-1:0]             m00_axis_tdata;
    logic [c_keep_w-1:0]             m00_axis_tkeep;
    logic                            m00_axis_tvalid;
    logic                            m00_axis_tlast;
    logic                            m00_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast,
        input  m00_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast,
        output m00_axis_tready
    );

endinterface
`default_nettype wire

// File: rtl/mac_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Searches the request
//            vector upward from last_grant+1 (wrapping modulo NUM_SOURCES)
//            and returns the first requester as a one-hot vector.
// Ports    : i_req        - request vector
//            i_last_grant - index of the previous winner
//            o_grant      - one-hot winner (all zeros when no request)
//            o_valid      - a winner exists
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mac_tx_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 2
) (
    input  logic [NUM_SOURCES-1:0] i_req,
    input  logic [c_idx_w-1:0]     i_last_grant,
    output logic [NUM_SOURCES-1:0] o_grant,
    output logic                   o_valid
);

    logic w_found;

    // Offset 1..NUM_SOURCES from the last winner; the last winner itself is
    // visited last so it only wins again when nobody else is asking.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            for (int j = 0; j < NUM_SOURCES; j++) begin
                if (!w_found && i_req[j] &&
                    (j == ((int'(i_last_grant) + i) % NUM_SOURCES))) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

    assign o_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_arbiter
// Purpose  : Packet-granular round-robin arbiter sharing the MAC transmit
//            AXI-Stream port between NUM_SOURCES user streams (i_txc domain).
//            A grant is held from the first beat to the tlast handshake.
//            When the granted source runs dry mid-packet while the MAC is
//            ready, the MAC aborts the frame; the arbiter pulses o_underrun
//            and swallows the rest of that packet so it never reaches the
//            MAC as a bogus new frame.
// Ports    : i_txc      - transmit clock
//            i_reset    - synchronous active-high reset
//            bus        - s_axis sources / m00_axis MAC stream (slave view)
//            o_grant    - one-hot current owner, zero when idle
//            o_underrun - single-cycle underrun pulse
//            o_pkt_count, o_drop_count - only with MAC_TX_ARB_STATS_EN
// Config   : `define MAC_TX_ARB_STATS_EN adds the packet/drop counters.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx_arbiter
    import mac_tx_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 2
) (
    input  logic                   i_txc,
    input  logic                   i_reset,
    mac_tx_arbiter_if.slave        bus,
    output logic [NUM_SOURCES-1:0] o_grant,
    output logic                   o_underrun
`ifdef MAC_TX_ARB_STATS_EN
    ,
    output logic [31:0]            o_pkt_count,
    output logic [15:0]            o_drop_count
`endif
);

    tx_arb_state_t          r_state;
    tx_arb_state_t          w_next_state;
    logic [NUM_SOURCES-1:0] r_grant;
    logic [NUM_SOURCES-1:0] w_next_grant;
    logic [c_idx_w-1:0]     r_last_grant;
    logic [c_idx_w-1:0]     w_next_last_grant;
    logic                   r_mid_pkt;
    logic                   w_next_mid_pkt;

    logic [NUM_SOURCES-1:0] w_pick_grant;
    logic                   w_pick_valid;

    logic [c_data_w-1:0]    w_sel_data;
    logic [c_keep_w-1:0]    w_sel_keep;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic                   w_xfer;
    logic                   w_underrun;

    rr_pick #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_rr_pick (
        .i_req        (bus.s_axis_tvalid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_valid      (w_pick_valid)
    );

    // AND-OR mux over the one-hot grant; yields zeros when nothing is granted.
    always_comb begin
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int n = 0; n < NUM_SOURCES; n++) begin
            if (r_grant[n]) begin
                w_sel_data  = w_sel_data  | bus.s_axis_tdata[n*c_data_w +: c_data_w];
                w_sel_keep  = w_sel_keep  | bus.s_axis_tkeep[n*c_keep_w +: c_keep_w];
                w_sel_valid = w_sel_valid | bus.s_axis_tvalid[n];
                w_sel_last  = w_sel_last  | bus.s_axis_tlast[n];
            end
        end
    end

    assign w_xfer = (r_state == PASS) && w_sel_valid && bus.m00_axis_tready;

    // The MAC only sees the granted stream while passing; in DROP the owner
    // is drained with tready held high and nothing is forwarded.
    always_comb begin
        bus.m00_axis_tvalid = 1'b0;
        bus.m00_axis_tdata  = '0;
        bus.m00_axis_tkeep  = '0;
        bus.m00_axis_tlast  = 1'b0;
        bus.s_axis_tready   = '0;
        case (r_state)
            PASS: begin
                bus.m00_axis_tvalid = w_sel_valid;
                bus.m00_axis_tdata  = w_sel_data;
                bus.m00_axis_tkeep  = w_sel_keep;
                bus.m00_axis_tlast  = w_sel_last;
                bus.s_axis_tready   = r_grant & {NUM_SOURCES{bus.m00_axis_tready}};
            end
            DROP: begin
                bus.s_axis_tready   = r_grant;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_grant      = r_grant;
        w_next_last_grant = r_last_grant;
        w_next_mid_pkt    = r_mid_pkt;
        w_underrun        = 1'b0;
        case (r_state)
            ARB: begin
                if (w_pick_valid) begin
                    w_next_grant      = w_pick_grant;
                    w_next_last_grant = onehot_to_idx(MAX_SOURCES'(w_pick_grant));
                    w_next_mid_pkt    = 1'b0;
                    w_next_state      = PASS;
                end
            end
            PASS: begin
                if (w_xfer) begin
                    w_next_mid_pkt = 1'b1;
                    if (w_sel_last) begin
                        w_next_grant = '0;
                        w_next_state = ARB;
                    end
                end else if (r_mid_pkt && bus.m00_axis_tready && !w_sel_valid) begin
                    // Source ran dry while the MAC was ready: frame is lost.
                    // A stall (MAC tready low) with tvalid low is harmless.
                    w_underrun   = 1'b1;
                    w_next_state = DROP;
                end
            end
            DROP: begin
                if (w_sel_valid && w_sel_last) begin
                    w_next_grant = '0;
                    w_next_state = ARB;
                end
            end
            default: begin
                w_next_grant = '0;
                w_next_state = ARB;
            end
        endcase
    end

    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            r_state      <= ARB;
            r_grant      <= '0;
            r_last_grant <= c_idx_w'(NUM_SOURCES - 1);
            r_mid_pkt    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_last_grant;
            r_mid_pkt    <= w_next_mid_pkt;
        end
    end

    assign o_grant    = r_grant;
    assign o_underrun = w_underrun;

`ifdef MAC_TX_ARB_STATS_EN
    logic [31:0] r_pkt_count;
    logic [15:0] r_drop_count;
    logic        w_pkt_done;

    assign w_pkt_done = w_xfer && w_sel_last;

    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_underrun) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign o_pkt_count  = r_pkt_count;
    assign o_drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_tx_arbiter
// Purpose  : Self-checking bench for mac_tx_arbiter. A 2-source instance
//            covers fairness, underrun, MAC stall and mid-packet reset; a
//            4-source instance covers the first-grant order after reset.
//            Expected beats are queued when packets are loaded and popped
//            on each m00 handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tx_arbiter;
    import mac_tx_arb_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          gap;
        int          src;
    } beat_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst4 = 1'b1;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_tx_arbiter_if #(.NUM_SOURCES(2)) bus2 ();
    mac_tx_arbiter_if #(.NUM_SOURCES(4)) bus4 ();

    logic [1:0] grant2;
    logic       underrun2;
    logic [3:0] grant4;
    logic       underrun4;
`ifdef MAC_TX_ARB_STATS_EN
    logic [31:0] pkt_count2, pkt_count4;
    logic [15:0] drop_count2, drop_count4;
`endif

    mac_tx_arbiter #(.NUM_SOURCES(2)) u_dut2 (
        .i_txc        (clk),
        .i_reset      (rst),
        .bus          (bus2),
        .o_grant      (grant2),
        .o_underrun   (underrun2)
`ifdef MAC_TX_ARB_STATS_EN
        ,
        .o_pkt_count  (pkt_count2),
        .o_drop_count (drop_count2)
`endif
    );

    mac_tx_arbiter #(.NUM_SOURCES(4)) u_dut4 (
        .i_txc        (clk),
        .i_reset      (rst4),
        .bus          (bus4),
        .o_grant      (grant4),
        .o_underrun   (underrun4)
`ifdef MAC_TX_ARB_STATS_EN
        ,
        .o_pkt_count  (pkt_count4),
        .o_drop_count (drop_count4)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- source model and scoreboard (2-source instance) -------
    beat_t src_q[2][$];
    beat_t exp_q[$];
    int    fb_q[$];
    int    gap_cnt[2];
    bit    armed[2];
    bit    toggle[2];
    int    sent[2];
    bit    in_pkt     = 1'b0;
    bit    stall_chk  = 1'b0;
    int    n_underrun = 0;

    function automatic logic [63:0] mk_data(input int src, input int pkt, input int beat);
        return {16'hDA7A, 8'(src), 8'(pkt), 8'(beat), 24'h5A5A5A};
    endfunction

    function automatic logic [63:0] mk_data4(input int src);
        return {32'hF00D_0000, 32'(src)};
    endfunction

    task automatic load_pkt(input int src, input int pkt, input int nbeats,
                            input int gap_at, input int gap_len, input int n_exp);
        for (int b = 0; b < nbeats; b++) begin
            beat_t t;
            t.data = mk_data(src, pkt, b);
            t.keep = (b == nbeats - 1) ? 8'h0F : 8'hFF;
            t.last = (b == nbeats - 1);
            t.gap  = (b == gap_at) ? gap_len : 0;
            t.src  = src;
            src_q[src].push_back(t);
            if (b < n_exp) exp_q.push_back(t);
        end
    endtask

    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            logic v;
            v = 1'b0;
            if (src_q[n].size() > 0) begin
                if (!armed[n]) begin
                    gap_cnt[n] = src_q[n][0].gap;
                    armed[n]   = 1'b1;
                end
                if (gap_cnt[n] > 0) gap_cnt[n]--;
                else v = !(toggle[n] && cyc[0]);
                bus2.s_axis_tdata[n*64 +: 64] = src_q[n][0].data;
                bus2.s_axis_tkeep[n*8 +: 8]   = src_q[n][0].keep;
                bus2.s_axis_tlast[n]          = src_q[n][0].last;
            end else begin
                bus2.s_axis_tdata[n*64 +: 64] = '0;
                bus2.s_axis_tkeep[n*8 +: 8]   = '0;
                bus2.s_axis_tlast[n]          = 1'b0;
            end
            bus2.s_axis_tvalid[n] = v;
        end
    endtask

    task automatic cycle();
        bit hs[2];
        @(negedge clk);
        for (int n = 0; n < 2; n++) hs[n] = bus2.s_axis_tvalid[n] && bus2.s_axis_tready[n];
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (hs[n] && src_q[n].size() > 0) begin
                void'(src_q[n].pop_front());
                armed[n] = 1'b0;
                sent[n]++;
            end
        end
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int max_cyc);
        int k;
        k = 0;
        while ((src_q[0].size() != 0 || src_q[1].size() != 0 || exp_q.size() != 0) && k < max_cyc) begin
            cycle();
            k++;
        end
        check_val({tag, "_drained"}, 64'(src_q[0].size() + src_q[1].size() + exp_q.size()), 64'd0);
    endtask

    task automatic reset_dut2();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            src_q[n].delete();
            armed[n]  = 1'b0;
            toggle[n] = 1'b0;
            sent[n]   = 0;
        end
        exp_q.delete();
        fb_q.delete();
        bus2.m00_axis_tready = 1'b1;
        drive();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // m00 monitor: every MAC-side handshake must match the next expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (underrun2) n_underrun++;
        if (bus2.m00_axis_tvalid && bus2.m00_axis_tready) begin
            if (!in_pkt) fb_q.push_back(cyc);
            in_pkt = !bus2.m00_axis_tlast;
            if (exp_q.size() == 0) begin
                check_val("m00_unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("m00_data",  bus2.m00_axis_tdata, e.data);
                check_val("m00_keep",  64'(bus2.m00_axis_tkeep), 64'(e.keep));
                check_val("m00_last",  64'(bus2.m00_axis_tlast), 64'(e.last));
                check_val("m00_grant", 64'(grant2), 64'd1 << e.src);
            end
        end
        if (stall_chk) begin
            check_val("stall_no_underrun", 64'(underrun2), 64'd0);
            if (bus2.m00_axis_tvalid && exp_q.size() > 0)
                check_val("stall_data_hold", bus2.m00_axis_tdata, exp_q[0].data);
        end
        if (rst) in_pkt = 1'b0;
    end

    // ---------------- 4-source first-grant monitor --------------------------
    int exp4_q[$];
    int first4 = -1;

    always @(negedge clk) begin
        int s;
        if (!rst4 && bus4.m00_axis_tvalid && bus4.m00_axis_tready && exp4_q.size() > 0) begin
            if (first4 < 0) first4 = cyc;
            s = exp4_q.pop_front();
            check_val("g4_grant", 64'(grant4), 64'd1 << s);
            check_val("g4_data", bus4.m00_axis_tdata, mk_data4(s));
            check_val("g4_no_underrun", 64'(underrun4), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int u0;
        int k;

        bus2.s_axis_tvalid   = '0;
        bus2.s_axis_tdata    = '0;
        bus2.s_axis_tkeep    = '0;
        bus2.s_axis_tlast    = '0;
        bus2.m00_axis_tready = 1'b1;
        bus4.s_axis_tvalid   = '0;
        bus4.s_axis_tlast    = '1;
        bus4.s_axis_tkeep    = '1;
        bus4.m00_axis_tready = 1'b1;
        for (int n = 0; n < 4; n++) bus4.s_axis_tdata[n*64 +: 64] = mk_data4(n);

        // ---- reset state ----
        reset_dut2();
        check_val("rst_grant",    64'(grant2), 64'd0);
        check_val("rst_tready",   64'(bus2.s_axis_tready), 64'd0);
        check_val("rst_tvalid",   64'(bus2.m00_axis_tvalid), 64'd0);
        check_val("rst_tlast",    64'(bus2.m00_axis_tlast), 64'd0);
        check_val("rst_tdata",    bus2.m00_axis_tdata, 64'd0);
        check_val("rst_tkeep",    64'(bus2.m00_axis_tkeep), 64'd0);
        check_val("rst_underrun", 64'(underrun2), 64'd0);
`ifdef MAC_TX_ARB_STATS_EN
        check_val("rst_pkt_count",  64'(pkt_count2), 64'd0);
        check_val("rst_drop_count", 64'(drop_count2), 64'd0);
`endif

        // ---- fairness: two sources, three 3-beat packets each ----
        for (int p = 0; p < 3; p++) begin
            load_pkt(0, p, 3, -1, 0, 3);
            load_pkt(1, p, 3, -1, 0, 3);
        end
        c0 = cyc;
        drive();
        run_until_idle("fair", 200);
        check_val("fair_pkts_seen", 64'(fb_q.size()), 64'd6);
        if (fb_q.size() > 0) check_val("fair_first_latency", 64'(fb_q[0] - c0), 64'd1);
        for (int i = 1; i < fb_q.size(); i++)
            check_val("fair_arb_gap", 64'(fb_q[i] - fb_q[i-1]), 64'd4);
        check_val("fair_idle_grant", 64'(grant2), 64'd0);
`ifdef MAC_TX_ARB_STATS_EN
        check_val("fair_pkt_count", 64'(pkt_count2), 64'd6);
`endif

        // ---- underrun: source 1, 6 beats, one empty cycle after beat 2 ----
        reset_dut2();
        u0 = n_underrun;
        load_pkt(1, 0, 6, 2, 1, 2);
        drive();
        run_until_idle("underrun", 100);
        check_val("underrun_pulses",   64'(n_underrun - u0), 64'd1);
        check_val("underrun_consumed", 64'(sent[1]), 64'd6);
        check_val("underrun_released", 64'(grant2), 64'd0);
`ifdef MAC_TX_ARB_STATS_EN
        check_val("underrun_drop_count", 64'(drop_count2), 64'd1);
        check_val("underrun_pkt_count",  64'(pkt_count2), 64'd0);
`endif

        // ---- stall: MAC tready low 5 cycles mid-packet, source toggles ----
        reset_dut2();
        load_pkt(0, 0, 4, -1, 0, 4);
        drive();
        k = 0;
        while (sent[0] < 2 && k < 50) begin cycle(); k++; end
        check_val("stall_reach_beat3", 64'(sent[0]), 64'd2);
        u0 = n_underrun;
        bus2.m00_axis_tready = 1'b0;
        stall_chk = 1'b1;
        toggle[0] = 1'b1;
        repeat (4) cycle();
        toggle[0] = 1'b0;
        cycle();
        bus2.m00_axis_tready = 1'b1;
        stall_chk = 1'b0;
        run_until_idle("stall", 50);
        check_val("stall_underruns", 64'(n_underrun - u0), 64'd0);
`ifdef MAC_TX_ARB_STATS_EN
        check_val("stall_pkt_count",  64'(pkt_count2), 64'd1);
        check_val("stall_drop_count", 64'(drop_count2), 64'd0);
`endif

        // ---- reset during beat 3 of source 0, then both request ----
        reset_dut2();
        load_pkt(0, 0, 6, -1, 0, 3);
        drive();
        k = 0;
        while (sent[0] < 2 && k < 50) begin cycle(); k++; end
        rst = 1'b1;
        cycle();
        check_val("rstmid_grant",  64'(grant2), 64'd0);
        check_val("rstmid_tvalid", 64'(bus2.m00_axis_tvalid), 64'd0);
        check_val("rstmid_tready", 64'(bus2.s_axis_tready), 64'd0);
        for (int n = 0; n < 2; n++) begin
            src_q[n].delete();
            armed[n] = 1'b0;
        end
        rst = 1'b0;
        load_pkt(0, 1, 3, -1, 0, 3);
        load_pkt(1, 1, 3, -1, 0, 3);
        drive();
        run_until_idle("rstmid_recover", 100);

        // ---- first grant order with four simultaneous requesters ----
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) exp4_q.push_back(n % 4);
        rst4 = 1'b0;
        bus4.s_axis_tvalid = 4'hF;
        c0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        check_val("g4_order_done", 64'(exp4_q.size()), 64'd0);
        check_val("g4_first_latency", 64'(first4 - c0), 64'd1);
`ifdef MAC_TX_ARB_STATS_EN
        check_val("g4_pkt_count", 64'(pkt_count4), 64'd5);
`endif
        rst4 = 1'b1;
        bus4.s_axis_tvalid = 4'h0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
